// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - programmable clock divider with run, single-step and halt modes
module clock_divider_prog #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 1024
) (
    input  logic                 CLK_IN,
    input  logic                 RESET,
    input  logic [CNT_WIDTH-1:0] DIV_IN,
    input  logic                 DIV_LOAD,
    input  logic [1:0]           MODE,
    input  logic                 STEP,
    output logic                 CLK_OUT,
    output logic                 TICK,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] DIV_CUR
);

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;

    localparam logic [CNT_WIDTH-1:0] DEF_DIV =
        (DEFAULT_DIV < 2) ? CNT_WIDTH'(2) : CNT_WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] div_cur;
    logic [CNT_WIDTH-1:0] div_pend;
    logic [CNT_WIDTH-1:0] high_len;
    logic [CNT_WIDTH-1:0] low_len;
    logic                 clk_r;
    logic                 tick_r;
    logic                 busy_r;
    logic                 start_period;

    function automatic logic [CNT_WIDTH-1:0] clamp_div(input logic [CNT_WIDTH-1:0] d);
        return (d < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : d;
    endfunction

    // Odd divisors give the extra cycle to the high phase.
    assign low_len  = div_cur >> 1;
    assign high_len = div_cur - low_len;

    always_comb begin
        start_period = 1'b0;
        case (state)
            ST_IDLE: start_period = (MODE == MODE_RUN) || ((MODE == MODE_STEP) && STEP);
            ST_LOW:  start_period = (cnt == low_len) && (MODE == MODE_RUN);
            default: start_period = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            clk_r    <= 1'b0;
            tick_r   <= 1'b0;
            busy_r   <= 1'b0;
            div_cur  <= DEF_DIV;
            div_pend <= DEF_DIV;
        end else begin
            tick_r <= 1'b0;
            if (DIV_LOAD) begin
                div_pend <= clamp_div(DIV_IN);
            end
            // A load on the same edge still sees the old pending value here.
            if (start_period) begin
                state   <= ST_HIGH;
                cnt     <= CNT_WIDTH'(1);
                clk_r   <= 1'b1;
                tick_r  <= 1'b1;
                busy_r  <= 1'b1;
                div_cur <= div_pend;
            end else begin
                case (state)
                    ST_HIGH: begin
                        if (cnt == high_len) begin
                            state <= ST_LOW;
                            cnt   <= CNT_WIDTH'(1);
                            clk_r <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                    ST_LOW: begin
                        if (cnt == low_len) begin
                            state  <= ST_IDLE;
                            cnt    <= '0;
                            busy_r <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        clk_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CLK_OUT = clk_r;
    assign TICK    = tick_r;
    assign BUSY    = busy_r;
    assign DIV_CUR = div_cur;

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - directed self-checking bench for clock_divider_prog
module tb_clock_divider_prog;

    logic        CLK_IN = 1'b0;
    logic        RESET;
    logic [15:0] DIV_IN;
    logic        DIV_LOAD;
    logic [1:0]  MODE;
    logic        STEP;
    logic        CLK_OUT;
    logic        TICK;
    logic        BUSY;
    logic [15:0] DIV_CUR;

    int checks = 0;
    int errors = 0;

    clock_divider_prog #(.CNT_WIDTH(16), .DEFAULT_DIV(1024)) dut (
        .CLK_IN   (CLK_IN),
        .RESET    (RESET),
        .DIV_IN   (DIV_IN),
        .DIV_LOAD (DIV_LOAD),
        .MODE     (MODE),
        .STEP     (STEP),
        .CLK_OUT  (CLK_OUT),
        .TICK     (TICK),
        .BUSY     (BUSY),
        .DIV_CUR  (DIV_CUR)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic cyc();
        @(posedge CLK_IN);
        #1;
    endtask

    // Records n samples, first sample in the most significant used bit.
    task automatic capture(input int n, output logic [63:0] c, output logic [63:0] t,
                           output logic [63:0] b);
        c = '0; t = '0; b = '0;
        for (int i = 0; i < n; i++) begin
            c = {c[62:0], CLK_OUT};
            t = {t[62:0], TICK};
            b = {b[62:0], BUSY};
            cyc();
        end
    endtask

    task automatic start_run(input logic [15:0] d);
        RESET = 1'b1; MODE = 2'b10; DIV_LOAD = 1'b0; STEP = 1'b0;
        cyc();
        RESET = 1'b0; DIV_IN = d; DIV_LOAD = 1'b1;
        cyc();
        DIV_LOAD = 1'b0; MODE = 2'b00;
        cyc();
    endtask

    task automatic test_reset();
        RESET = 1'b1; MODE = 2'b10; DIV_IN = 16'd0; DIV_LOAD = 1'b0; STEP = 1'b0;
        cyc(); cyc();
        checks++;
        if ({CLK_OUT, TICK, BUSY} !== 3'b000) begin
            errors++; $display("FAIL reset_outputs got %b want 000", {CLK_OUT, TICK, BUSY});
        end
        checks++;
        if (DIV_CUR !== 16'd1024) begin
            errors++; $display("FAIL reset_div_cur got %0d want 1024", DIV_CUR);
        end
        RESET = 1'b0; MODE = 2'b00;
        cyc();
        checks++;
        if ({CLK_OUT, TICK, BUSY} !== 3'b111) begin
            errors++; $display("FAIL first_edge got %b want 111", {CLK_OUT, TICK, BUSY});
        end
    endtask

    task automatic test_default_run();
        int bad = 0;
        int ticks = 0;
        for (int i = 0; i < 2048; i++) begin
            if (CLK_OUT !== ((i % 1024) < 512)) bad++;
            if (TICK !== ((i % 1024) == 0)) bad++;
            if (TICK === 1'b1) ticks++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL run1024_pattern got %0d bad samples want 0", bad);
        end
        checks++;
        if (ticks != 2) begin
            errors++; $display("FAIL run1024_ticks got %0d want 2", ticks);
        end
        checks++;
        if (DIV_CUR !== 16'd1024) begin
            errors++; $display("FAIL run1024_div_cur got %0d want 1024", DIV_CUR);
        end
    endtask

    task automatic test_odd_and_clamp();
        logic [63:0] c, t, b;
        start_run(16'd5);
        checks++;
        if (DIV_CUR !== 16'd5) begin
            errors++; $display("FAIL odd_div_cur got %0d want 5", DIV_CUR);
        end
        capture(10, c, t, b);
        checks++;
        if (c !== 64'b1110011100 || t !== 64'b1000010000) begin
            errors++; $display("FAIL odd5_pattern got clk %b tick %b want 1110011100 1000010000",
                               c[9:0], t[9:0]);
        end
        for (int k = 0; k < 2; k++) begin
            start_run(16'(k));
            checks++;
            if (DIV_CUR !== 16'd2) begin
                errors++; $display("FAIL clamp%0d_div_cur got %0d want 2", k, DIV_CUR);
            end
            capture(4, c, t, b);
            checks++;
            if (c !== 64'b1010 || t !== 64'b1010) begin
                errors++; $display("FAIL clamp%0d_pattern got clk %b tick %b want 1010 1010",
                                   k, c[3:0], t[3:0]);
            end
        end
    endtask

    task automatic test_div_change();
        logic [63:0] c, t, b;
        start_run(16'd8);
        DIV_IN = 16'd4; DIV_LOAD = 1'b1;
        cyc();
        DIV_LOAD = 1'b0;
        checks++;
        if (DIV_CUR !== 16'd8) begin
            errors++; $display("FAIL chg_div_cur_early got %0d want 8", DIV_CUR);
        end
        capture(7, c, t, b);
        checks++;
        if (c !== 64'b1110000 || t !== 64'b0) begin
            errors++; $display("FAIL chg_first_period got clk %b tick %b want 1110000 0000000",
                               c[6:0], t[6:0]);
        end
        checks++;
        if (DIV_CUR !== 16'd4 || TICK !== 1'b1) begin
            errors++; $display("FAIL chg_apply got div %0d tick %b want 4 1", DIV_CUR, TICK);
        end
        capture(8, c, t, b);
        checks++;
        if (c !== 64'b11001100 || t !== 64'b10001000) begin
            errors++; $display("FAIL chg_new_period got clk %b tick %b want 11001100 10001000",
                               c[7:0], t[7:0]);
        end
    endtask

    task automatic test_load_on_entry();
        start_run(16'd4);
        cyc(); cyc(); cyc();
        DIV_IN = 16'd6; DIV_LOAD = 1'b1;
        cyc();
        DIV_LOAD = 1'b0;
        checks++;
        if (TICK !== 1'b1 || DIV_CUR !== 16'd4) begin
            errors++; $display("FAIL entry_load_old got tick %b div %0d want 1 4", TICK, DIV_CUR);
        end
        cyc(); cyc(); cyc(); cyc();
        checks++;
        if (TICK !== 1'b1 || DIV_CUR !== 16'd6) begin
            errors++; $display("FAIL entry_load_new got tick %b div %0d want 1 6", TICK, DIV_CUR);
        end
    endtask

    task automatic test_step();
        logic [63:0] c, t, b;
        RESET = 1'b1; MODE = 2'b01; STEP = 1'b0; DIV_LOAD = 1'b0;
        cyc();
        RESET = 1'b0; DIV_IN = 16'd6; DIV_LOAD = 1'b1;
        cyc();
        DIV_LOAD = 1'b0;
        cyc();
        checks++;
        if ({CLK_OUT, BUSY} !== 2'b00) begin
            errors++; $display("FAIL step_idle got %b want 00", {CLK_OUT, BUSY});
        end
        STEP = 1'b1;
        cyc();
        c = '0; t = '0; b = '0;
        for (int i = 0; i < 10; i++) begin
            c = {c[62:0], CLK_OUT};
            t = {t[62:0], TICK};
            b = {b[62:0], BUSY};
            STEP = (i == 2);
            cyc();
        end
        STEP = 1'b0;
        checks++;
        if (c !== 64'b1110000000 || t !== 64'b1000000000 || b !== 64'b1111110000) begin
            errors++; $display("FAIL single_step got clk %b tick %b busy %b want 1110000000 1000000000 1111110000",
                               c[9:0], t[9:0], b[9:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] c, t, b;
        RESET = 1'b1; MODE = 2'b01; STEP = 1'b0; DIV_LOAD = 1'b0;
        cyc();
        RESET = 1'b0; DIV_IN = 16'd2; DIV_LOAD = 1'b1;
        cyc();
        DIV_LOAD = 1'b0; STEP = 1'b1;
        cyc();
        capture(6, c, t, b);
        STEP = 1'b0;
        checks++;
        if (c !== 64'b100100 || t !== 64'b100100 || b !== 64'b110110) begin
            errors++; $display("FAIL step_held got clk %b tick %b busy %b want 100100 100100 110110",
                               c[5:0], t[5:0], b[5:0]);
        end
    endtask

    task automatic test_halt();
        logic [63:0] c, t, b;
        start_run(16'd10);
        cyc();
        MODE = 2'b10;
        capture(14, c, t, b);
        checks++;
        if (c !== 64'b11110000000000 || t !== 64'b0 || b !== 64'b11111111100000) begin
            errors++; $display("FAIL halt_mid got clk %b tick %b busy %b want 11110000000000 0 11111111100000",
                               c[13:0], t[13:0], b[13:0]);
        end
    endtask

    task automatic test_reset_mid();
        start_run(16'd6);
        cyc(); cyc(); cyc();
        checks++;
        if ({CLK_OUT, BUSY} !== 2'b01) begin
            errors++; $display("FAIL rmid_in_low got %b want 01", {CLK_OUT, BUSY});
        end
        RESET = 1'b1;
        cyc();
        checks++;
        if ({CLK_OUT, TICK, BUSY} !== 3'b000 || DIV_CUR !== 16'd1024) begin
            errors++; $display("FAIL rmid_abort got %b div %0d want 000 1024",
                               {CLK_OUT, TICK, BUSY}, DIV_CUR);
        end
        RESET = 1'b0; MODE = 2'b00;
        cyc();
        checks++;
        if ({CLK_OUT, TICK, BUSY} !== 3'b111) begin
            errors++; $display("FAIL rmid_restart got %b want 111", {CLK_OUT, TICK, BUSY});
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_odd_and_clamp();
        test_div_change();
        test_load_on_entry();
        test_step();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
